// File: rtl/templatized_alu_sequencer.sv
// templatized_alu_sequencer
// Issue controller and round-robin arbiter in front of the shared templatized
// ALU. Two requesters submit (op, a, b) over valid/ready. Each granted
// operation is decoded into the ALU group enables {arith, logic, shift}. The
// enables are held for the group latency, then the ALU result is captured and
// returned over a valid/ready response channel. Illegal opcodes (9-15) are
// answered with an error response and never reach the ALU.
//
// Optional feature macro: TEMPLATIZED_ALU_SEQ_FASTPATH_EN
//   When this macro is defined, a pending request can be granted in the same
//   cycle that the response is accepted, so the FSM skips IDLE.
//   When it is undefined, the FSM always passes through IDLE between
//   operations.

module templatized_alu_sequencer #(
    parameter int WIDTH     = 32,
    parameter int ARITH_LAT = 1,
    parameter int LOGIC_LAT = 1,
    parameter int SHIFT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [3:0]       alu_op_code,
    output logic [2:0]       alu_en,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id,
    output logic             rsp_err
);

    localparam int MAX_AL  = (ARITH_LAT > LOGIC_LAT) ? ARITH_LAT : LOGIC_LAT;
    localparam int MAX_LAT = (MAX_AL > SHIFT_LAT) ? MAX_AL : SHIFT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // The counter is loaded with latency-1 and the FSM leaves EXEC when it
    // reaches zero, so the counter never wraps.
    localparam logic [CNT_W-1:0] ARITH_CNT = CNT_W'(ARITH_LAT - 1);
    localparam logic [CNT_W-1:0] LOGIC_CNT = CNT_W'(LOGIC_LAT - 1);
    localparam logic [CNT_W-1:0] SHIFT_CNT = CNT_W'(SHIFT_LAT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             rr_ptr;
    logic [2:0]       en_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;
    logic             id_q;
    logic             err_q;

    logic             can_grant;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_en;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_legal;

    // Round-robin arbitration. rr_ptr holds the last winner; on a tie the
    // other requester wins. ready is held low during reset so that all
    // outputs stay at zero.
    always_comb begin
        can_grant = 1'b0;
        if (rst_n) begin
            if (state == IDLE) begin
                can_grant = 1'b1;
            end
`ifdef TEMPLATIZED_ALU_SEQ_FASTPATH_EN
            else if (state == RESP && rsp_ready) begin
                can_grant = 1'b1;
            end
`endif
        end
        grant0    = can_grant && req0_valid && (!req1_valid || rr_ptr);
        grant1    = can_grant && req1_valid && (!req0_valid || !rr_ptr);
        grant_any = grant0 || grant1;
    end

    // Select the winning request and decode its opcode into group enables
    // and the counter load value.
    always_comb begin
        sel_op    = grant1 ? req1_op : req0_op;
        sel_a     = grant1 ? req1_a  : req0_a;
        sel_b     = grant1 ? req1_b  : req0_b;
        sel_en    = 3'b000;
        sel_cnt   = '0;
        sel_legal = 1'b0;
        case (sel_op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                sel_en    = 3'b100;
                sel_cnt   = ARITH_CNT;
                sel_legal = 1'b1;
            end
            4'd4: begin
                sel_en    = 3'b010;
                sel_cnt   = LOGIC_CNT;
                sel_legal = 1'b1;
            end
            4'd5, 4'd6, 4'd7, 4'd8: begin
                sel_en    = 3'b001;
                sel_cnt   = SHIFT_CNT;
                sel_legal = 1'b1;
            end
            default: begin
                sel_en    = 3'b000;
                sel_cnt   = '0;
                sel_legal = 1'b0;
            end
        endcase
    end

    // Main FSM. The grant load sits after the case so that it overrides the
    // RESP->IDLE move when the fast path grants straight out of RESP.
    // Illegal opcodes leave the ALU-facing registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b1;
            en_q     <= 3'b000;
            op_q     <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result_q <= alu_result;
                        err_q    <= 1'b0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (grant_any) begin
                rr_ptr <= grant1;
                id_q   <= grant1;
                if (sel_legal) begin
                    op_q  <= sel_op;
                    a_q   <= sel_a;
                    b_q   <= sel_b;
                    en_q  <= sel_en;
                    cnt   <= sel_cnt;
                    state <= EXEC;
                end else begin
                    err_q    <= 1'b1;
                    result_q <= '0;
                    state    <= RESP;
                end
            end
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign alu_en      = (state == EXEC) ? en_q : 3'b000;
    assign alu_op_code = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = (state == RESP);
    assign rsp_result  = result_q;
    assign rsp_id      = id_q;
    assign rsp_err     = err_q;

endmodule
